// File: rtl/descramble_multi_pkg.sv
// Shared constants and types for the multi-lane 100BASE-TX descrambler.
// LFSR is x^11 + x^9 + 1; taps are indices into the 11-bit state register.
package descramble_multi_pkg;

    localparam int unsigned LFSR_WIDTH = 11;
    localparam int unsigned TAP_A      = 8;
    localparam int unsigned TAP_B      = 10;

    localparam int unsigned DEF_CONSECUTIVE_IDLES = 29;
    localparam int unsigned DEF_UNLOCK_CYCLES     = 45125;
    localparam int unsigned DEF_JUMBO_CYCLES      = 72000;
    localparam int unsigned DEF_TEST_CYCLES       = 625;

    typedef logic [LFSR_WIDTH-1:0] lfsr_t;

    typedef enum logic [1:0] {
        TmoNormal,
        TmoJumbo,
        TmoTest
    } tmo_sel_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/descramble_multi_step.sv
// Combinational single-bit descrambler step: one LFSR advance for one received bit.
// While unlocked the state is fed from the line (self-sync); once locked it free-runs.
module descramble_step
    import descramble_multi_pkg::*;
(
    input  logic [LFSR_WIDTH-1:0] s,
    input  logic                  b,
    input  logic                  locked,
    output logic [LFSR_WIDTH-1:0] s_next,
    output logic                  d,
    output logic                  is_one
);

    logic k;

    assign k      = s[TAP_A] ^ s[TAP_B];
    assign d      = b ^ k;
    assign is_one = d;
    assign s_next = {s[LFSR_WIDTH-2:0], locked ? k : ~b};

endmodule

// File: rtl/descramble_multi.sv
// 100BASE-TX receive descrambler taking up to LANES bits per clock (MSB first),
// with idle-run lock detection and a mode-selectable unlock timeout.
module descramble_multi
    import descramble_multi_pkg::*;
#(
    parameter int unsigned LANES             = 2,
    parameter int unsigned CONSECUTIVE_IDLES = DEF_CONSECUTIVE_IDLES,
    parameter int unsigned UNLOCK_CYCLES     = DEF_UNLOCK_CYCLES,
    parameter int unsigned JUMBO_CYCLES      = DEF_JUMBO_CYCLES,
    parameter int unsigned TEST_CYCLES       = DEF_TEST_CYCLES,
    localparam int unsigned CW               = $clog2(LANES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LANES-1:0] scrambled,
    input  logic [CW-1:0]    scrambled_count,
    input  logic             signal_status,
    input  logic             test_mode,
    input  logic             jumbo_mode,
    output logic [LANES-1:0] descrambled,
    output logic [CW-1:0]    descrambled_count,
    output logic             locked,
    output logic             lock_lost
);

    localparam int unsigned TW = $clog2(max3(UNLOCK_CYCLES, JUMBO_CYCLES, TEST_CYCLES) + 1);
    localparam int unsigned RW = $clog2(CONSECUTIVE_IDLES + 1);

    lfsr_t            lfsr_q;
    logic [RW-1:0]    run_q, run_d;
    logic             relock_q, relock_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             locked_q, locked_d;
    logic             lock_lost_q;
    logic [LANES-1:0] descrambled_q;
    logic [CW-1:0]    count_q;

    logic [CW-1:0]    count_eff;
    lfsr_t            chain [LANES+1];
    logic [LANES-1:0] valid, d_raw, one_bits, d_gated;
    tmo_sel_t         tmo_sel;

    assign count_eff = (scrambled_count > CW'(LANES)) ? CW'(LANES) : scrambled_count;
    assign chain[0]  = lfsr_q;

    // Stage i handles the i-th bit in time order, i.e. input position LANES-1-i.
    for (genvar i = 0; i < LANES; i++) begin : g_stage
        lfsr_t s_step;

        assign valid[i] = (count_eff > CW'(i));

        descramble_step u_step (
            .s      (chain[i]),
            .b      (scrambled[LANES-1-i]),
            .locked (locked_q),
            .s_next (s_step),
            .d      (d_raw[i]),
            .is_one (one_bits[i])
        );

        assign chain[i+1]          = valid[i] ? s_step : chain[i];
        assign d_gated[LANES-1-i]  = valid[i] & d_raw[i];
    end

    // Idle-run counter; wraps to 0 on each completed run so sustained idle re-triggers.
    always_comb begin
        run_d    = run_q;
        relock_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (valid[i]) begin
                if (one_bits[i]) begin
                    if (run_d == RW'(CONSECUTIVE_IDLES - 1)) begin
                        run_d    = '0;
                        relock_d = 1'b1;
                    end else begin
                        run_d = run_d + 1'b1;
                    end
                end else begin
                    run_d = '0;
                end
            end
        end
    end

    assign tmo_sel = test_mode ? TmoTest : (jumbo_mode ? TmoJumbo : TmoNormal);

    always_comb begin
        timer_d = timer_q;
        if (relock_q) begin
            case (tmo_sel)
                TmoTest:  timer_d = TW'(TEST_CYCLES);
                TmoJumbo: timer_d = TW'(JUMBO_CYCLES);
                default:  timer_d = TW'(UNLOCK_CYCLES);
            endcase
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end
        if (!signal_status) begin
            timer_d = '0;
        end
    end

    assign locked_d = (timer_d != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q        <= '0;
            run_q         <= '0;
            relock_q      <= 1'b0;
            timer_q       <= '0;
            locked_q      <= 1'b0;
            lock_lost_q   <= 1'b0;
            descrambled_q <= '0;
            count_q       <= '0;
        end else begin
            if (count_eff != '0) begin
                descrambled_q <= d_gated;
            end
            count_q     <= count_eff;
            timer_q     <= timer_d;
            locked_q    <= locked_d;
            lock_lost_q <= locked_q & ~locked_d;
            if (!signal_status) begin
                lfsr_q   <= '0;
                run_q    <= '0;
                relock_q <= 1'b0;
            end else begin
                lfsr_q   <= chain[LANES];
                run_q    <= run_d;
                relock_q <= relock_d;
            end
        end
    end

    assign descrambled       = descrambled_q;
    assign descrambled_count = count_q;
    assign locked            = locked_q;
    assign lock_lost         = lock_lost_q;

endmodule
